// File: rtl/metronome_pkg.sv
// Shared state encoding, default click constants and counter sizing helper
// for the metronome click generator.
package metronome_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StClick
  } click_state_e;

  localparam int unsigned DefHalfPeriod = 24;
  localparam int unsigned DefBurstLen   = 480;
  localparam int unsigned DefDecayLen   = 96;
  localparam logic [15:0] DefAmpNormal  = 16'h2000;
  localparam logic [15:0] DefAmpAccent  = 16'h4000;

  // Bits needed to count 0..v-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/click_envelope.sv
// Click amplitude envelope: loads an initial amplitude and halves it every
// DECAY_LEN served samples.
module click_envelope
  import metronome_pkg::*;
#(
  parameter int unsigned DECAY_LEN = DefDecayLen
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] load_amp,
  input  logic        step,
  input  logic        clear,
  output logic [15:0] amp
);

  localparam int unsigned    DW        = cnt_width(DECAY_LEN);
  localparam logic [DW-1:0]  DecayLast = DW'(DECAY_LEN - 1);

  logic [DW-1:0] decay_cnt;
  logic [DW-1:0] base_cnt;
  logic [15:0]   base_amp;

  // A load in the same cycle as a step takes effect before the step.
  always_comb begin
    base_amp = load ? load_amp : amp;
    base_cnt = load ? '0 : decay_cnt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      amp       <= '0;
      decay_cnt <= '0;
    end else if (clear) begin
      amp       <= '0;
      decay_cnt <= '0;
    end else if (step) begin
      if (base_cnt == DecayLast) begin
        decay_cnt <= '0;
        amp       <= base_amp >> 1;
      end else begin
        decay_cnt <= base_cnt + 1'b1;
        amp       <= base_amp;
      end
    end else begin
      amp       <= base_amp;
      decay_cnt <= base_cnt;
    end
  end

endmodule

// File: rtl/metronome_click.sv
// Metronome click generator: a decaying square-wave burst started on each
// tick rising edge, served one sample per codec request.
module metronome_click
  import metronome_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = DefHalfPeriod,
  parameter int unsigned BURST_LEN   = DefBurstLen,
  parameter int unsigned DECAY_LEN   = DefDecayLen,
  parameter logic [15:0] AMP_NORMAL  = DefAmpNormal,
  parameter logic [15:0] AMP_ACCENT  = DefAmpAccent
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic [2:0]         speed,
  input  logic               sample_req,
  output logic signed [15:0] sample,
  output logic               sample_valid,
  output logic               click_active,
  output logic [1:0]         beat_count
);

  localparam int unsigned   HW         = cnt_width(HALF_PERIOD);
  localparam int unsigned   SW         = cnt_width(BURST_LEN);
  localparam logic [HW-1:0] HalfLast   = HW'(HALF_PERIOD - 1);
  localparam logic [SW-1:0] SampleLast = SW'(BURST_LEN - 1);

  click_state_e  state, state_d;
  logic          tick_d;
  logic          phase;
  logic [HW-1:0] half_cnt;
  logic [SW-1:0] sample_cnt;
  logic [15:0]   amp;

  logic          trigger, stopped, in_click, serve_click, burst_end;
  logic          eff_phase;
  logic [HW-1:0] eff_half;
  logic [SW-1:0] eff_scnt;
  logic [15:0]   init_amp, eff_amp, sample_d;

  // eff_* are the burst variables after a same-cycle trigger is applied.
  always_comb begin
    stopped     = (speed == 3'd0);
    trigger     = tick & ~tick_d & ~stopped;
    init_amp    = (beat_count == 2'd0) ? AMP_ACCENT : AMP_NORMAL;
    in_click    = trigger | (state == StClick);
    eff_phase   = trigger ? 1'b1 : phase;
    eff_half    = trigger ? '0 : half_cnt;
    eff_scnt    = trigger ? '0 : sample_cnt;
    eff_amp     = trigger ? init_amp : amp;
    serve_click = sample_req & in_click;
    burst_end   = serve_click & (eff_scnt == SampleLast);
    sample_d    = '0;
    if (serve_click) sample_d = eff_phase ? eff_amp : 16'h0 - eff_amp;
    state_d = state;
    if (stopped || burst_end) state_d = StIdle;
    else if (trigger)         state_d = StClick;
  end

  click_envelope #(
    .DECAY_LEN(DECAY_LEN)
  ) u_envelope (
    .clk     (clk),
    .reset   (reset),
    .load    (trigger),
    .load_amp(init_amp),
    .step    (serve_click),
    .clear   (burst_end | stopped),
    .amp     (amp)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= StIdle;
      tick_d       <= 1'b1;
      sample       <= '0;
      sample_valid <= 1'b0;
      click_active <= 1'b0;
      sample_cnt   <= '0;
      half_cnt     <= '0;
      phase        <= 1'b1;
      beat_count   <= '0;
    end else begin
      tick_d       <= tick;
      state        <= state_d;
      click_active <= (state_d == StClick);
      sample_valid <= sample_req;
      if (sample_req) sample <= sample_d;

      if (stopped)      beat_count <= '0;
      else if (trigger) beat_count <= beat_count + 2'd1;

      if (state_d == StIdle) begin
        sample_cnt <= '0;
        half_cnt   <= '0;
        phase      <= 1'b1;
      end else if (serve_click) begin
        sample_cnt <= eff_scnt + 1'b1;
        if (eff_half == HalfLast) begin
          half_cnt <= '0;
          phase    <= ~eff_phase;
        end else begin
          half_cnt <= eff_half + 1'b1;
          phase    <= eff_phase;
        end
      end else begin
        sample_cnt <= eff_scnt;
        half_cnt   <= eff_half;
        phase      <= eff_phase;
      end
    end
  end

endmodule

// File: tb/tb_metronome_click.sv
// Scoreboard bench for metronome_click: requests push expected samples, a
// monitor pops and compares on every sample_valid strobe.
module tb_metronome_click;

  logic               clk = 1'b0;
  logic               reset;
  logic               tick;
  logic [2:0]         speed;
  logic               sample_req;
  logic signed [15:0] sample;
  logic               sample_valid;
  logic               click_active;
  logic [1:0]         beat_count;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_exp;

  always #5 clk = ~clk;

  metronome_click dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .speed       (speed),
    .sample_req  (sample_req),
    .sample      (sample),
    .sample_valid(sample_valid),
    .click_active(click_active),
    .beat_count  (beat_count)
  );

  // Sample n (1-based) of a burst starting at amplitude a0 with default params.
  function automatic logic [15:0] exp_sample(input int n, input logic [15:0] a0);
    logic [15:0] m;
    m = a0 >> ((n - 1) / 96);
    if (((n - 1) / 24) % 2 == 0) return m;
    return 16'h0 - m;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic serve(input logic [15:0] e);
    sample_req = 1'b1;
    exp_q.push_back(e);
    step();
    sample_req = 1'b0;
    step();
  endtask

  task automatic serve_burst(input int first, input int last, input logic [15:0] a0);
    for (int n = first; n <= last; n++) serve(exp_sample(n, a0));
  endtask

  task automatic tick_edge();
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
  endtask

  always @(negedge clk) begin
    if (sample_valid) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_valid: got sample %h with no request pending", sample);
      end else begin
        mon_exp = exp_q.pop_front();
        if (sample !== mon_exp) begin
          n_fail++;
          $display("FAIL sample: got %h, expected %h", sample, mon_exp);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; tick = 1'b1; speed = 3'd2; sample_req = 1'b0;
    repeat (2) step();
    check("reset_click_active", click_active, 0);
    check("reset_beat_count", beat_count, 0);
    check("reset_sample_valid", sample_valid, 0);
    check("reset_sample", sample, 0);

    // Tick held high through reset release must not click.
    reset = 1'b0;
    repeat (3) step();
    check("tick_high_no_click", click_active, 0);
    serve(16'h0);
    serve(16'h0);
    check("tick_high_still_idle", click_active, 0);
    tick = 1'b0;
    step();

    // Accented beat, run to burst end.
    tick_edge();
    check("beat_after_first", beat_count, 1);
    check("click_active_first", click_active, 1);
    serve_burst(1, 479, 16'h4000);
    check("click_active_before_end", click_active, 1);
    serve(exp_sample(480, 16'h4000));
    check("click_active_after_480", click_active, 0);
    serve(16'h0);

    // Unaccented beat with first halving.
    tick_edge();
    check("beat_after_second", beat_count, 2);
    serve_burst(1, 97, 16'h2000);

    // Tick edge coincident with a request restarts the burst.
    tick = 1'b1;
    sample_req = 1'b1;
    exp_q.push_back(16'h2000);
    step();
    tick = 1'b0;
    sample_req = 1'b0;
    step();
    check("beat_after_restart", beat_count, 3);
    serve_burst(2, 25, 16'h2000);
    check("click_active_restart", click_active, 1);

    // beat_count wrap, then accent again.
    tick_edge();
    check("beat_wrap", beat_count, 0);
    tick_edge();
    check("beat_after_wrap", beat_count, 1);
    serve(16'h4000);

    // Stop: abort burst, zero beat, ignore ticks.
    speed = 3'd0;
    step();
    check("stop_beat_count", beat_count, 0);
    check("stop_click_active", click_active, 0);
    tick_edge();
    check("stopped_tick_ignored", click_active, 0);
    check("stopped_beat_zero", beat_count, 0);
    serve(16'h0);

    // Reset in mid-burst.
    speed = 3'd2;
    tick_edge();
    serve(exp_sample(1, 16'h4000));
    serve(exp_sample(2, 16'h4000));
    sample_req = 1'b1;
    reset = 1'b1;
    #1;
    check("midreset_click_active", click_active, 0);
    check("midreset_sample_valid", sample_valid, 0);
    step();
    sample_req = 1'b0;
    reset = 1'b0;
    repeat (3) step();
    check("after_reset_idle", click_active, 0);
    serve(16'h0);

    step();
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
